ntt8_naive_core: RTL and testbench

Sequential 8-point naive NTT engine. It consumes the twiddle table produced by the omega-generator stage (`omegas[i] = omega^i mod q`) and the modulus. It accepts 8 input samples over a valid/ready stream and emits the 8 transform bins `X[k] = Σ_j x[j]·omega^(j·k) mod q` over a second valid/ready stream. It is the compute stage directly downstream of the omega generator in the naive FNTT datapath.

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_mod_mac.sv | 31 +++
 rtl/ntt8_naive_core.sv | 131 +++++++++++++
 tb/tb_ntt8_naive_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the naive FNTT datapath
// (omega generator and the NTT compute core).
package ntt_pkg;

  localparam int W = 8;
  localparam int N = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_EMIT
  } ntt_state_t;

  typedef logic [W-1:0] word_t;
  typedef word_t [N-1:0] twiddle_tbl_t;

endpackage

// File: rtl/ntt_mod_mac.sv
// Combinational modular multiply-accumulate: (acc + (x*w mod q)) reduced to [0, q).
// acc is always < q, so a single conditional subtract finishes the reduction.
module ntt_mod_mac #(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] x,
  input  logic [W-1:0] w,
  input  logic [W-1:0] q,
  output logic [W-1:0] sum
);

  localparam int PW = 2 * W;

  logic [PW-1:0] prod;
  logic [W-1:0]  prod_red;
  logic [W:0]    raw;

  assign prod     = PW'(x) * PW'(w);
  assign prod_red = W'(prod % PW'(q));
  assign raw      = {1'b0, acc} + {1'b0, prod_red};

  // NOTE: assigning sum before the if gives every path a value, so no latch is inferred.
  always_comb begin
    sum = raw[W-1:0];
    if (raw >= {1'b0, q}) begin
      sum = W'(raw - {1'b0, q});
    end
  end

endmodule

// File: rtl/ntt8_naive_core.sv
// Sequential 8-point naive NTT: loads 8 samples, runs one modular MAC per cycle,
// and streams the 8 bins X[k] = sum_j x[j]*omega^(j*k) mod q out over valid/ready.
module ntt8_naive_core #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          mod,
  input  logic [N-1:0][W-1:0]   omegas,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [2:0]            out_index,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import ntt_pkg::*;

  localparam logic [2:0] LAST = 3'(N - 1);

  ntt_state_t           state;
  logic [W-1:0]         q_r;
  logic [N-1:0][W-1:0]  tbl;
  logic [N-1:0][W-1:0]  x_buf;
  logic [2:0]           j;
  logic [2:0]           k;
  logic [W-1:0]         acc;
  logic [W-1:0]         mac_out;
  logic [W-1:0]         x_red;
  logic [2:0]           tw_idx;

  // Twiddle exponent j*k wraps mod 8 because omega has order 8.
  assign tw_idx = j * k;
  assign x_red  = in_data % q_r;

  ntt_mod_mac #(.W(W)) u_mac (
    .acc (acc),
    .x   (x_buf[j]),
    .w   (tbl[tw_idx]),
    .q   (q_r),
    .sum (mac_out)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: sample buffer and twiddle table are reset too, so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      q_r       <= '0;
      tbl       <= '0;
      x_buf     <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mod >= W'(2)) begin
              q_r      <= mod;
              tbl      <= omegas;
              j        <= '0;
              k        <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            x_buf[j] <= x_red;
            j        <= j + 3'd1;
            if (j == LAST) begin
              j        <= '0;
              k        <= '0;
              acc      <= '0;
              in_ready <= 1'b0;
              state    <= ST_COMPUTE;
            end
          end
        end
        ST_COMPUTE: begin
          acc <= mac_out;
          j   <= j + 3'd1;
          if (j == LAST) begin
            out_data  <= mac_out;
            out_index <= k;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              k     <= k + 3'd1;
              j     <= '0;
              acc   <= '0;
              state <= ST_COMPUTE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt8_naive_core.sv
// Self-checking bench for ntt8_naive_core: fixed and random transforms checked
// against a direct-sum reference, plus error, backpressure and abort sequences.
module tb_ntt8_naive_core;

  typedef struct {
    int q;
    int om[8];
    int x[8];
    int exp_x[8];
    int stall_k;
    int stall_len;
    bit extra_start;
  } vec_t;

  localparam int NV = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       mod = '0;
  logic [7:0][7:0]  omegas = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [2:0]       out_index;
  logic             busy;
  logic             done;
  logic             err;

  int tests = 0;
  int fails = 0;
  vec_t vecs[NV];

  ntt8_naive_core #(.N(8), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mod       (mod),
    .omegas    (omegas),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: the transform as a direct sum, reduced once at the end.
  function automatic int ref_bin(input int q, input int om[8], input int x[8], input int k);
    longint s = 0;
    for (int jj = 0; jj < 8; jj++) s += longint'(x[jj]) * longint'(om[(jj * k) % 8]);
    return int'(s % longint'(q));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_index"}, out_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Runs one transform; abort_k >= 0 asserts reset while computing bin abort_k.
  task automatic run_vec(input vec_t v, input int abort_k);
    int cycles;
    int n;
    int slen;
    slen = (v.stall_k >= 0) ? v.stall_len : 0;
    mod = 8'(v.q);
    for (int i = 0; i < 8; i++) omegas[i] = 8'(v.om[i]);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
    cycles = 0;
    for (int jj = 0; jj < 8; jj++) begin
      in_valid = 1'b1;
      in_data  = 8'(v.x[jj]);
      if (v.extra_start && jj == 3) begin
        start = 1'b1;
        mod   = 8'd5;
      end
      step();
      cycles++;
      start = 1'b0;
      mod   = 8'(v.q);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_k) begin
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        out_ready = 1'b0;
        return;
      end
      n = 0;
      while (!out_valid && n < 40) begin
        step();
        cycles++;
        n++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 0, 1);
        out_ready = 1'b0;
        return;
      end
      check("bin_data", out_data, v.exp_x[k]);
      check("bin_index", out_index, k);
      check("ready_valid_overlap", in_ready & out_valid, 0);
      if (k == v.stall_k) begin
        out_ready = 1'b0;
        repeat (v.stall_len) begin
          step();
          cycles++;
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, v.exp_x[k]);
          check("stall_index", out_index, k);
        end
        out_ready = 1'b1;
      end
      step();
      cycles++;
    end
    out_ready = 1'b0;
    check("latency", cycles, 80 + slen);
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    step();
    check("done_single", done, 0);
  endtask

  initial begin
    int saw_done;

    vecs[0].q = 17;
    vecs[0].om = '{1, 2, 4, 8, 16, 15, 13, 9};
    vecs[0].x = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].exp_x = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[0].stall_k = -1;
    vecs[0].stall_len = 0;
    vecs[0].extra_start = 1'b0;

    vecs[1] = vecs[0];
    vecs[1].x = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1].exp_x = '{1, 2, 4, 8, 16, 15, 13, 9};
    vecs[1].extra_start = 1'b1;

    vecs[2] = vecs[0];
    vecs[2].x = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[2].exp_x = '{8, 0, 0, 0, 0, 0, 0, 0};

    vecs[3] = vecs[0];
    vecs[3].x = '{20, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].exp_x = '{3, 3, 3, 3, 3, 3, 3, 3};
    vecs[3].stall_k = 3;
    vecs[3].stall_len = 5;

    for (int i = 4; i < NV; i++) begin
      vecs[i].q = int'($urandom_range(2, 255));
      for (int t = 0; t < 8; t++) begin
        vecs[i].om[t] = int'($urandom_range(0, 255));
        vecs[i].x[t]  = int'($urandom_range(0, 255));
      end
      for (int k = 0; k < 8; k++) vecs[i].exp_x[k] = ref_bin(vecs[i].q, vecs[i].om, vecs[i].x, k);
      vecs[i].stall_k = (i % 2 == 0) ? int'($urandom_range(0, 7)) : -1;
      vecs[i].stall_len = int'($urandom_range(1, 4));
      vecs[i].extra_start = 1'b0;
    end

    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], -1);

    // Rejected start: modulus below 2.
    mod = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_in_ready", in_ready, 0);
    step();
    check("err_single", err, 0);
    check("err_busy_after", busy, 0);

    // Abort during COMPUTE of bin 4, then a clean rerun.
    run_vec(vecs[0], 4);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (20) begin
      step();
      if (done) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_idle_busy", busy, 0);
    run_vec(vecs[0], -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
